// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and iterative multiply / divide.
// Optional divider: define ALU_DIV_EN to compile in DIVU/REMU (ops B/C).
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       flags,
   output logic             err
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [SHW:0] ITERS = (SHW+1)'(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] ra, rb, acc;
   logic [3:0]       rop;
   logic [SHW:0]     cnt;
   logic             multi, legal, fin;
   logic [WIDTH-1:0] res;
   logic             c_flag, v_flag;
   logic [WIDTH:0]   add_s, sub_s;

`ifdef ALU_DIV_EN
   // Restoring divider: acc holds the partial remainder, ra shifts dividend out / quotient in.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_dif;
   assign rem_sh  = {acc, ra[WIDTH-1]};
   assign rem_dif = rem_sh[WIDTH-1:0] - rb;
`endif

   always_comb begin
      multi = (rop == 4'hA);
      legal = (rop <= 4'hA);
`ifdef ALU_DIV_EN
      multi = multi | (rop == 4'hB) | (rop == 4'hC);
      legal = (rop <= 4'hC);
`endif
   end

   // Single-cycle ops finalize on their first BUSY cycle; iterative ops after ITERS steps.
   assign fin       = multi ? (cnt == ITERS) : 1'b1;
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   assign add_s = {1'b0, ra} + {1'b0, rb};
   assign sub_s = {1'b0, ra} + {1'b0, ~rb} + (WIDTH+1)'(1);

   always_comb begin
      res    = '0;
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (rop)
         4'h0: begin
            res    = add_s[WIDTH-1:0];
            c_flag = add_s[WIDTH];
            v_flag = (ra[WIDTH-1] == rb[WIDTH-1]) && (add_s[WIDTH-1] != ra[WIDTH-1]);
         end
         4'h1: begin
            res    = sub_s[WIDTH-1:0];
            c_flag = sub_s[WIDTH];
            v_flag = (ra[WIDTH-1] != rb[WIDTH-1]) && (sub_s[WIDTH-1] != ra[WIDTH-1]);
         end
         4'h2: res = ra & rb;
         4'h3: res = ra | rb;
         4'h4: res = ra ^ rb;
         4'h5: res = ~(ra | rb);
         4'h6: res = {{(WIDTH-1){1'b0}}, ($signed(ra) < $signed(rb))};
         4'h7: res = ra << rb[SHW-1:0];
         4'h8: res = ra >> rb[SHW-1:0];
         4'h9: res = $signed(ra) >>> rb[SHW-1:0];
         4'hA: res = acc;
`ifdef ALU_DIV_EN
         4'hB: res = ra;
         4'hC: res = acc;
`endif
         default: res = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = BUSY;
         BUSY:    if (fin)       state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ra    <= '0;
         rb    <= '0;
         acc   <= '0;
         rop   <= '0;
         cnt   <= '0;
         out   <= '0;
         flags <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               ra  <= a;
               rb  <= b;
               rop <= op;
               acc <= '0;
               cnt <= '0;
            end
            BUSY: if (!fin) begin
               cnt <= cnt + 1'b1;
               if (rop == 4'hA) begin
                  if (rb[0]) acc <= acc + ra;
                  ra <= ra << 1;
                  rb <= rb >> 1;
               end
`ifdef ALU_DIV_EN
               else if (rem_sh >= {1'b0, rb}) begin
                  acc <= rem_dif;
                  ra  <= {ra[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= rem_sh[WIDTH-1:0];
                  ra  <= {ra[WIDTH-2:0], 1'b0};
               end
`endif
            end else begin
               out   <= res;
               flags <= {res[WIDTH-1], (res == '0), c_flag, v_flag};
               err   <= !legal;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed steps plus random ops
// against an arithmetic reference model.
module tb_alu_seq;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, err;
   logic [31:0] a = '0, b = '0, out;
   logic [3:0]  op = '0, flags;
   int          tests = 0, fails = 0;
   logic [31:0] last_out;

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .flags(flags), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain wide-integer arithmetic, flags derived from the true result.
   function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [3:0] f, output logic e,
                                 output int lat);
      longint          sx, sy;
      longint unsigned ux, uy;
      logic            c, v;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = 64'(x);
      uy = 64'(y);
      r = '0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 1;
      case (o)
         4'h0: begin r = 32'(ux + uy); c = ((ux + uy) >> 32) != 0; v = (sx + sy) != longint'($signed(r)); end
         4'h1: begin r = 32'(ux - uy); c = (ux >= uy); v = (sx - sy) != longint'($signed(r)); end
         4'h2: r = x & y;
         4'h3: r = x | y;
         4'h4: r = x ^ y;
         4'h5: r = ~(x | y);
         4'h6: r = (sx < sy) ? 32'd1 : 32'd0;
         4'h7: r = x << y[4:0];
         4'h8: r = x >> y[4:0];
         4'h9: r = 32'(sx >>> y[4:0]);
         4'hA: begin r = 32'(ux * uy); lat = 33; end
`ifdef ALU_DIV_EN
         4'hB: begin r = (y == 0) ? 32'hFFFFFFFF : x / y; lat = 33; end
         4'hC: begin r = (y == 0) ? x : x % y; lat = 33; end
`endif
         default: begin r = '0; e = 1'b1; end
      endcase
      f = {r[31], (r == 0), c, v};
   endfunction

   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int hold, input bit poke);
      logic [31:0] er;
      logic [3:0]  ef;
      logic        ee;
      int          el, n;
      bit          seen;
      model(o, x, y, er, ef, ee, el);
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      a = x; b = y; op = o; in_valid = 1'b1; out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
      n = 0;
      while (!out_valid && n < 100) begin
         in_valid = poke && (n == 3);
         chk("in_ready_busy", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      chk("latency", 32'(n), 32'(el));
      chk("out", out, er);
      chk("flags", 32'(flags), 32'(ef));
      chk("err", 32'(err), 32'(ee));
      last_out = out;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_out", out, er);
         chk("hold_valid_ready", 32'({out_valid, in_ready}), 32'b10);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("after_handshake", 32'({out_valid, in_ready}), 32'b01);
      if (poke) begin
         seen = 1'b0;
         repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
         chk("poke_ignored", 32'(seen), 32'd0);
      end
   endtask

   initial begin
      bit          seen;
      logic [3:0]  ro;
      logic [31:0] rx, ry;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready_valid", 32'({in_ready, out_valid}), 32'b10);
      chk("rst_out", out, 32'd0);
      chk("rst_flags_err", 32'({flags, err}), 32'd0);
      rst = 1'b0;

      for (int o = 0; o <= 6; o++) run_op(4'(o), 32'd5, 32'd2, 0, 1'b0);
      run_op(4'h0, 32'd5, 32'd2, 0, 1'b0);  chk("add_5_2", last_out, 32'd7);
      run_op(4'h5, 32'd5, 32'd2, 0, 1'b0);  chk("nor_5_2", last_out, 32'hFFFFFFF8);

      run_op(4'h0, 32'h7FFFFFFF, 32'd1, 0, 1'b0);
      chk("ovf_flags", 32'(flags), 32'b1001);
      run_op(4'h0, 32'hFFFFFFFF, 32'd1, 0, 1'b0);
      chk("carry_flags", 32'(flags), 32'b0110);
      run_op(4'h1, 32'd2, 32'd5, 0, 1'b0);
      chk("sub_borrow", last_out, 32'hFFFFFFFD);

      run_op(4'hA, 32'h0001_0003, 32'h0000_0005, 0, 1'b1);
      chk("mul_const", last_out, 32'h0005_000F);

`ifdef ALU_DIV_EN
      run_op(4'hB, 32'd100, 32'd7, 0, 1'b0);  chk("divu", last_out, 32'd14);
      run_op(4'hC, 32'd100, 32'd7, 0, 1'b0);  chk("remu", last_out, 32'd2);
      run_op(4'hB, 32'd9, 32'd0, 0, 1'b0);    chk("divu0", last_out, 32'hFFFFFFFF);
      run_op(4'hC, 32'd9, 32'd0, 0, 1'b0);    chk("remu0", last_out, 32'd9);
`else
      run_op(4'hB, 32'd100, 32'd7, 0, 1'b0);  chk("opB_illegal_err", 32'(err), 32'd1);
`endif

      run_op(4'h4, 32'hDEADBEEF, 32'h12345678, 10, 1'b0);
      run_op(4'hE, 32'd1, 32'd1, 0, 1'b0);
      chk("opE_err", 32'(err), 32'd1);

      // Reset in the middle of a multiply: the op must vanish.
      @(negedge clk);
      a = 32'd3; b = 32'd7; op = 4'hA; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_busy_state", 32'({in_ready, out_valid}), 32'b10);
      chk("rst_busy_out", out, 32'd0);
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      chk("rst_busy_no_valid", 32'(seen), 32'd0);

      // Reset and in_valid together: reset wins.
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; op = 4'h0; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      seen = 1'b0;
      repeat (4) begin @(posedge clk); #1; if (out_valid || !in_ready) seen = 1'b1; end
      chk("rst_wins", 32'(seen), 32'd0);

      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(0, 15));
         rx = $urandom;
         ry = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         run_op(ro, rx, ry, int'($urandom_range(0, 2)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
